// File: rtl/package_settings.sv
// Project-wide data-path sizing shared by the shaping filter and its readers.
package package_settings;

  localparam int unsigned SIZE_FILTER_DATA = 15;

endpackage

// File: rtl/peak_reader_pkg.sv
// Shared types and defaults for the cusp peak reader (FSM states, event record).
package peak_reader_pkg;

  import package_settings::*;

  localparam int          PeakThresholdDefault = 200;
  localparam int unsigned PeakHoldoffDefault   = 8;
  localparam int unsigned PeakTsWDefault       = 32;
  localparam int unsigned PeakWidthWDefault    = 8;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StHoldoff
  } reader_state_e;

  typedef struct packed {
    logic signed [SIZE_FILTER_DATA:0] amplitude;
    logic [PeakTsWDefault-1:0]        ts;
    logic [PeakWidthWDefault-1:0]     width;
  } peak_event_t;

endpackage

// File: rtl/peak_reader_outreg.sv
// One-entry output register with valid/ready handshake; events arriving while a
// record is still pending (and not being accepted) are dropped and counted.
module peak_reader_outreg
  import peak_reader_pkg::*;
#(
  parameter type         rec_t = peak_event_t,
  parameter int unsigned LostW = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             emit_i,
  input  rec_t             rec_i,
  input  logic             ready_i,
  output logic             valid_o,
  output rec_t             rec_o,
  output logic [LostW-1:0] lost_o
);

  logic             valid_q, valid_d;
  rec_t             rec_q, rec_d;
  logic [LostW-1:0] lost_q, lost_d;
  logic             accept;

  assign accept = valid_q & ready_i;

  always_comb begin
    valid_d = valid_q;
    rec_d   = rec_q;
    lost_d  = lost_q;
    if (accept) begin
      valid_d = 1'b0;
    end
    if (emit_i) begin
      // A slot freed by this cycle's accept can take the new record directly.
      if (!valid_q || accept) begin
        rec_d   = rec_i;
        valid_d = 1'b1;
      end else if (lost_q != '1) begin
        lost_d = lost_q + LostW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
      lost_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
      lost_q  <= lost_d;
    end
  end

  assign valid_o = valid_q;
  assign rec_o   = rec_q;
  assign lost_o  = lost_q;

endmodule

// File: rtl/cusp_peak_reader.sv
// Threshold pulse detector / peak tracker on the shaped filter stream.
// Optional baseline subtraction is enabled with `define PEAK_READER_BASELINE_EN.
module cusp_peak_reader
  import package_settings::*;
  import peak_reader_pkg::*;
#(
  parameter int          THRESHOLD = PeakThresholdDefault,
  parameter int unsigned HOLDOFF   = PeakHoldoffDefault,
  parameter int unsigned TS_W      = PeakTsWDefault,
  parameter int unsigned WIDTH_W   = PeakWidthWDefault,
  parameter int unsigned LOST_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [SIZE_FILTER_DATA:0] input_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [SIZE_FILTER_DATA:0] peak_amplitude,
  output logic [TS_W-1:0]               peak_time,
  output logic [WIDTH_W-1:0]            peak_width,
  output logic [LOST_W-1:0]             lost_count,
  output logic                          busy
);

  localparam int unsigned DW = SIZE_FILTER_DATA + 1;

  typedef struct packed {
    logic signed [DW-1:0] amplitude;
    logic [TS_W-1:0]      ts;
    logic [WIDTH_W-1:0]   width;
  } rec_t;

`ifdef PEAK_READER_BASELINE_EN
  localparam int unsigned XW = DW + 1;
`else
  localparam int unsigned XW = DW;
`endif

  localparam logic signed [XW-1:0] ThrX        = XW'(THRESHOLD);
  localparam logic [7:0]           HoldoffLoad = (HOLDOFF == 0) ? 8'd0 : 8'(HOLDOFF - 1);

  reader_state_e        state_q, state_d;
  logic [TS_W-1:0]      ts_q;
  logic [TS_W-1:0]      max_ts_q, max_ts_d;
  logic signed [XW-1:0] max_q, max_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [7:0]           hcnt_q, hcnt_d;
  logic signed [XW-1:0] x;
  logic signed [DW-1:0] amp;
  logic                 above;
  logic                 emit;
  rec_t                 emit_rec, out_rec;

`ifdef PEAK_READER_BASELINE_EN
  logic signed [XW-1:0] base_q, base_d, diff;

  assign diff = $signed({input_data[DW-1], input_data}) - base_q;
  assign x    = diff;

  // Baseline only tracks while idle so a pulse cannot drag it upward.
  always_comb begin
    base_d = base_q;
    if (state_q == StIdle) begin
      base_d = base_q + (diff >>> 4);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
    end else begin
      base_q <= base_d;
    end
  end

  always_comb begin
    if (max_q[XW-1] != max_q[XW-2]) begin
      amp = max_q[XW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      amp = max_q[DW-1:0];
    end
  end
`else
  assign x   = input_data;
  assign amp = max_q;
`endif

  assign above = (x > ThrX);

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    max_ts_d = max_ts_q;
    width_d  = width_q;
    hcnt_d   = hcnt_q;
    emit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (above) begin
          max_d    = x;
          max_ts_d = ts_q;
          width_d  = WIDTH_W'(1);
          state_d  = StArmed;
        end
      end
      StArmed: begin
        if (above) begin
          if (width_q != '1) begin
            width_d = width_q + WIDTH_W'(1);
          end
          // Strict compare keeps the first sample of a plateau.
          if (x > max_q) begin
            max_d    = x;
            max_ts_d = ts_q;
          end
        end else begin
          emit = 1'b1;
          if (HOLDOFF == 0) begin
            state_d = StIdle;
          end else begin
            hcnt_d  = HoldoffLoad;
            state_d = StHoldoff;
          end
        end
      end
      StHoldoff: begin
        if (hcnt_q == 8'd0) begin
          state_d = StIdle;
        end else begin
          hcnt_d = hcnt_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ts_q     <= '0;
      max_q    <= '0;
      max_ts_q <= '0;
      width_q  <= '0;
      hcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_q + TS_W'(1);
      max_q    <= max_d;
      max_ts_q <= max_ts_d;
      width_q  <= width_d;
      hcnt_q   <= hcnt_d;
    end
  end

  always_comb begin
    emit_rec.amplitude = amp;
    emit_rec.ts        = max_ts_q;
    emit_rec.width     = width_q;
  end

  peak_reader_outreg #(
    .rec_t (rec_t),
    .LostW (LOST_W)
  ) u_outreg (
    .clk_i   (clk),
    .reset_i (reset),
    .emit_i  (emit),
    .rec_i   (emit_rec),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .rec_o   (out_rec),
    .lost_o  (lost_count)
  );

  assign peak_amplitude = out_rec.amplitude;
  assign peak_time      = out_rec.ts;
  assign peak_width     = out_rec.width;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_cusp_peak_reader.sv
// Directed bench for cusp_peak_reader with default parameters (THRESHOLD=200, HOLDOFF=8).
module tb_cusp_peak_reader;
  import package_settings::*;

  localparam int DW = SIZE_FILTER_DATA + 1;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic signed [DW-1:0] input_data = '0;
  logic                 out_ready = 1'b1;
  logic                 out_valid;
  logic signed [DW-1:0] peak_amplitude;
  logic [31:0]          peak_time;
  logic [7:0]           peak_width;
  logic [15:0]          lost_count;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  cusp_peak_reader dut (
    .clk            (clk),
    .reset          (reset),
    .input_data     (input_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .peak_amplitude (peak_amplitude),
    .peak_time      (peak_time),
    .peak_width     (peak_width),
    .lost_count     (lost_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are checked there too.
  task automatic do_reset();
    reset      = 1'b1;
    input_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input int v);
    input_data = DW'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic check_rec(input string tag, input int amp, input int t, input int w);
    check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_amp"}, 64'(peak_amplitude), 64'(amp));
    check_eq({tag, "_time"}, 64'(peak_time), 64'(t));
    check_eq({tag, "_width"}, 64'(peak_width), 64'(w));
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_amp", 64'(peak_amplitude), 64'd0);
    check_eq("rst_time", 64'(peak_time), 64'd0);
    check_eq("rst_width", 64'(peak_width), 64'd0);
    check_eq("rst_lost", 64'(lost_count), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // Ramp with 1000 at ts=20; 300..1000..300 is 15 samples above threshold
    repeat (10) drive(0);
    for (int i = 0; i <= 10; i++) drive(i * 100);
    for (int i = 9; i >= 2; i--) drive(i * 100);
    check_rec("ramp", 1000, 20, 15);
    check_eq("ramp_lost", 64'(lost_count), 64'd0);
    check_eq("ramp_busy", 64'(busy), 64'd1);
    drive(100);
    check_eq("ramp_accepted", 64'(out_valid), 64'd0);

    // Stalled consumer: second event dropped, first held
    do_reset();
    out_ready = 1'b0;
    drive(300); drive(500); drive(300); drive(0);
    check_rec("stall_first", 500, 1, 3);
    repeat (12) drive(0);
    drive(700); drive(0);
    check_eq("stall_lost", 64'(lost_count), 64'd1);
    check_rec("stall_held", 500, 1, 3);
    out_ready = 1'b1;
    drive(0);
    check_eq("stall_accept", 64'(out_valid), 64'd0);
    check_eq("stall_lost_keep", 64'(lost_count), 64'd1);

    // Holdoff: pulse starting 3 cycles after the previous one ends
    do_reset();
    drive(300); drive(300); drive(0);
    check_rec("ho_first", 300, 0, 2);
    drive(0);
    check_eq("ho_busy", 64'(busy), 64'd1);
    drive(0);
    repeat (6) drive(900);
    check_eq("ho_idle_busy", 64'(busy), 64'd0);
    check_eq("ho_no_rec", 64'(out_valid), 64'd0);
    drive(400); drive(600); drive(400); drive(0);
    check_rec("ho_second", 600, 12, 3);

    // Negative input then plateau at ts=50
    do_reset();
    repeat (50) drive(-500);
    check_eq("neg_valid", 64'(out_valid), 64'd0);
    check_eq("neg_busy", 64'(busy), 64'd0);
    drive(400); drive(400); drive(400); drive(0);
    check_rec("plateau", 400, 50, 3);

    // Reset on the fourth above-threshold sample
    do_reset();
    drive(300); drive(400); drive(500);
    reset      = 1'b1;
    input_data = DW'(600);
    @(posedge clk);
    #1 reset = 1'b0;
    check_eq("mid_valid", 64'(out_valid), 64'd0);
    check_eq("mid_amp", 64'(peak_amplitude), 64'd0);
    check_eq("mid_time", 64'(peak_time), 64'd0);
    check_eq("mid_width", 64'(peak_width), 64'd0);
    check_eq("mid_lost", 64'(lost_count), 64'd0);
    check_eq("mid_busy", 64'(busy), 64'd0);
    drive(0); drive(0);
    check_eq("mid_no_rec", 64'(out_valid), 64'd0);
    drive(500); drive(0);
    check_rec("mid_clean", 500, 2, 1);

    // Long pulse: width saturates at 255
    do_reset();
    repeat (300) drive(300);
    drive(0);
    check_rec("long", 300, 0, 255);
    check_eq("long_lost", 64'(lost_count), 64'd0);
    drive(0);
    check_eq("long_single", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
